// File: rtl/room_draw_scheduler.sv
// Round-robin icon redraw sequencer for the five floorplan rooms, plus a
// full-screen clear sweep, driving a VGA adapter plot interface.
module room_draw_scheduler #(
  parameter int BASE_X = 8,
  parameter int X_STEP = 30,
  parameter int ROOM_Y = 56,
  parameter int ICON_W = 8,
  parameter int ICON_H = 8,
  parameter int SCR_W  = 160,
  parameter int SCR_H  = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] req,
  input  logic [4:0] funct,
  input  logic [4:0] onoff,
  input  logic       clear_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [4:0] grant,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_DRAW  = 3'd2;
  localparam logic [2:0] S_CLR   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int OXW = $clog2(ICON_W);
  localparam int OYW = $clog2(ICON_H);

  logic [2:0]     state_q, state_d;
  logic [4:0]     pend_q, pend_d;
  logic           cpend_q, cpend_d;
  logic [2:0]     rr_q, rr_d;
  logic [2:0]     gidx_q, gidx_d;
  logic [4:0]     grant_q, grant_d;
  logic [2:0]     colour_q, colour_d;
  logic [7:0]     basex_q, basex_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic [7:0]     cx_q, cx_d;
  logic [6:0]     cy_q, cy_d;
  logic [7:0]     x_q, x_d;
  logic [6:0]     y_q, y_d;
  logic           plot_q, plot_d;
  logic           done_q, done_d;

  logic [2:0]     cand, sel;
  logic           found;
  logic [4:0]     pend_clr;
  logic           cpend_clr;

  function automatic logic [2:0] icon_colour(input logic is_light, input logic is_on);
    if (is_light) return is_on ? 3'b110 : 3'b001;
    else          return is_on ? 3'b100 : 3'b010;
  endfunction

  // First pending room at or after the round-robin pointer, wrapping 4 -> 0.
  always_comb begin
    cand  = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cand = 3'((int'(rr_q) + k) % 5);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gidx_d    = gidx_q;
    grant_d   = grant_q;
    colour_d  = colour_q;
    basex_d   = basex_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    x_d       = x_q;
    y_d       = y_q;
    plot_d    = 1'b0;
    done_d    = 1'b0;
    pend_clr  = '0;
    cpend_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpend_q) begin
          state_d   = S_CLR;
          cpend_clr = 1'b1;
          cx_d      = '0;
          cy_d      = '0;
          x_d       = '0;
          y_d       = '0;
          colour_d  = 3'b000;
          plot_d    = 1'b1;
        end else if (found) begin
          state_d  = S_LATCH;
          gidx_d   = sel;
          grant_d  = 5'b00001 << sel;
          pend_clr = 5'b00001 << sel;
          rr_d     = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
        end
      end
      S_LATCH: begin
        // Room attributes are frozen here; later input changes do not touch this icon.
        colour_d = icon_colour(funct[gidx_q], onoff[gidx_q]);
        basex_d  = 8'(BASE_X + int'(gidx_q) * X_STEP);
        ox_d     = '0;
        oy_d     = '0;
        x_d      = basex_d;
        y_d      = 7'(ROOM_Y);
        plot_d   = 1'b1;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (ox_q == OXW'(ICON_W - 1) && oy_q == OYW'(ICON_H - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (ox_q == OXW'(ICON_W - 1)) begin
            ox_d = '0;
            oy_d = oy_q + 1'b1;
          end else begin
            ox_d = ox_q + 1'b1;
          end
          x_d    = basex_q + 8'(ox_d);
          y_d    = 7'(ROOM_Y) + 7'(oy_d);
          plot_d = 1'b1;
        end
      end
      S_CLR: begin
        if (cx_q == 8'(SCR_W - 1) && cy_q == 7'(SCR_H - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (cx_q == 8'(SCR_W - 1)) begin
            cx_d = '0;
            cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
          x_d    = cx_d;
          y_d    = cy_d;
          plot_d = 1'b1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A request arriving on its own grant edge survives and causes one more redraw.
    pend_d  = (pend_q & ~pend_clr) | req;
    cpend_d = (cpend_q & ~cpend_clr) | clear_req;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      cpend_q  <= 1'b0;
      rr_q     <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      colour_q <= '0;
      basex_q  <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cpend_q  <= cpend_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      colour_q <= colour_d;
      basex_q  <= basex_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_room_draw_scheduler.sv
// Bench for room_draw_scheduler: directed scenarios plus random requests,
// compared every cycle against a job-timeline reference model.
module tb_room_draw_scheduler;

  localparam int IW = 8, IH = 8, SW = 160, SH = 120, BX = 8, XS = 30, RY = 56;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] req, funct, onoff;
  logic       clear_req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
  logic [4:0] grant;

  room_draw_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .funct(funct), .onoff(onoff),
    .clear_req(clear_req), .x(x), .y(y), .colour(colour), .plot(plot),
    .grant(grant), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int passes = 0, total = 0;
  int cyc = 0;
  // Model: one job at a time (0 none, 1 icon, 2 clear) with its start edge.
  int m_kind, m_t0, m_room, m_rr;
  logic [4:0] m_pend;
  logic       m_cpend;
  logic [2:0] m_col;
  logic [7:0] h_x;
  logic [6:0] h_y;
  logic [2:0] h_col;
  logic [25:0] expv;
  int n_plot, n_done;
  logic [2:0] last_col;
  logic [4:0] prev_grant;
  int glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [2:0] col_of(input logic f, input logic o);
    if (f) return o ? 3'b110 : 3'b001;
    return o ? 3'b100 : 3'b010;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_t0 = 0; m_room = 0; m_rr = 0;
    m_pend = '0; m_cpend = 1'b0; m_col = '0;
    h_x = '0; h_y = '0; h_col = '0;
  endtask

  task automatic model_edge();
    logic [4:0] gmask;
    logic       gclr;
    int el;
    gmask = '0;
    gclr  = 1'b0;
    if (m_kind == 0) begin
      if (m_cpend) begin
        m_kind = 2; m_t0 = cyc; gclr = 1'b1;
      end else if (m_pend != 0) begin
        for (int k = 0; k < 5; k++) begin
          int r;
          r = (m_rr + k) % 5;
          if (m_pend[r]) begin m_room = r; break; end
        end
        m_kind = 1; m_t0 = cyc; m_rr = (m_room + 1) % 5;
        gmask[m_room] = 1'b1;
      end
    end else begin
      el = cyc - m_t0;
      if (m_kind == 1 && el == 1) m_col = col_of(funct[m_room], onoff[m_room]);
      if ((m_kind == 1 && el == IW*IH + 2) || (m_kind == 2 && el == SW*SH + 1)) m_kind = 0;
    end
    m_pend  = (m_pend & ~gmask) | req;
    m_cpend = (m_cpend & ~gclr) | clear_req;
  endtask

  task automatic model_outputs();
    logic p, d, b;
    logic [4:0] g;
    int el, k;
    p = 0; d = 0; b = 0; g = '0;
    el = cyc - m_t0;
    if (m_kind == 1) begin
      b = 1; g = 5'b00001 << m_room;
      if (el >= 1 && el <= IW*IH) begin
        k = el - 1; p = 1;
        h_x = 8'(BX + m_room*XS + k % IW);
        h_y = 7'(RY + k / IW);
        h_col = m_col;
      end else if (el == IW*IH + 1) d = 1;
    end else if (m_kind == 2) begin
      b = 1;
      if (el < SW*SH) begin
        p = 1; h_x = 8'(el % SW); h_y = 7'(el / SW); h_col = 3'b000;
      end else d = 1;
    end
    expv = {p, d, b, g, h_col, h_y, h_x};
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    if (reset) model_edge();
    model_outputs();
    @(negedge clock);
    chk("outs", 32'({plot, done, busy, grant, colour, y, x}), 32'(expv));
    if (plot) begin n_plot++; last_col = colour; end
    if (done) n_done++;
    if (grant != 0 && prev_grant == 0) glog.push_back(int'(grant));
    prev_grant = grant;
  endtask

  task automatic clear_stats();
    n_plot = 0; n_done = 0; glog.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    step();
    reset = 1'b1;
    clear_stats();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    do begin step(); c++; end
    while ((m_kind != 0 || m_pend != 0 || m_cpend) && c < budget);
    step();
    chk(tag, 32'(c < budget), 32'd1);
  endtask

  task automatic wait_plots(input string tag, input int n);
    int c;
    c = 0;
    while (n_plot < n && c < 500) begin step(); c++; end
    chk(tag, 32'(n_plot >= n), 32'd1);
  endtask

  initial begin
    req = '0; funct = '0; onoff = '0; clear_req = 1'b0;
    prev_grant = '0; last_col = '0;
    model_reset(); clear_stats();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_outs", 32'({plot, done, busy, grant, colour, y, x}), 32'd0);
    step(); step();
    reset = 1'b1;

    // Single light-on icon in room 2
    funct = 5'b00100; onoff = 5'b00100; req = 5'b00100;
    step();
    req = '0;
    wait_idle("t1_to", 200);
    chk("t1_plots", n_plot, 64);
    chk("t1_done", n_done, 1);
    chk("t1_ngrant", glog.size(), 1);
    chk("t1_grant", glog[0], 5'b00100);
    chk("t1_col", last_col, 3'b110);

    // Two rooms requested together from reset
    do_reset();
    funct = 5'b00000; onoff = 5'b01000; req = 5'b01001;
    step();
    req = '0;
    wait_idle("t2_to", 400);
    chk("t2_plots", n_plot, 128);
    chk("t2_done", n_done, 2);
    chk("t2_g0", glog[0], 5'b00001);
    chk("t2_g1", glog[1], 5'b01000);

    // Round-robin pointer moves past room 0
    do_reset();
    req = 5'b00001; step(); req = '0;
    wait_idle("t3a_to", 200);
    clear_stats();
    req = 5'b00011; step(); req = '0;
    wait_idle("t3_to", 400);
    chk("t3_g0", glog[0], 5'b00010);
    chk("t3_g1", glog[1], 5'b00001);

    // Clear requested mid-icon, with another room pending
    do_reset();
    funct = 5'b10010; onoff = 5'b00010;
    req = 5'b10000; step();
    req = 5'b00010; step();
    req = '0;
    wait_plots("t4_px", 21);
    clear_req = 1'b1; step(); clear_req = 1'b0;
    wait_idle("t4_to", 20000);
    chk("t4_plots", n_plot, 64 + SW*SH + 64);
    chk("t4_done", n_done, 3);
    chk("t4_g0", glog[0], 5'b10000);
    chk("t4_g1", glog[1], 5'b00010);

    // Re-request during own draw: drawn twice, door unlocked
    do_reset();
    funct = '0; onoff = '0;
    req = 5'b00100; step(); req = '0;
    wait_plots("t5_px", 10);
    req = 5'b00100; step(); req = '0;
    wait_idle("t5_to", 400);
    chk("t5_plots", n_plot, 128);
    chk("t5_ngrant", glog.size(), 2);
    chk("t5_col", last_col, 3'b010);

    // Asynchronous reset mid-draw
    do_reset();
    req = 5'b00001; step(); req = '0;
    wait_plots("t6_px", 5);
    #2 reset = 1'b0;
    #1;
    chk("t6_plot", plot, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_grant", grant, 5'b00000);
    model_reset();
    n_done = 0;
    step(); step();
    reset = 1'b1;
    repeat (6) step();
    chk("t6_done", n_done, 0);
    chk("t6_plots", n_plot, 5);

    // Random requests and room states
    do_reset();
    repeat (2500) begin
      req   = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'b00000;
      funct = 5'($urandom);
      onoff = 5'($urandom);
      step();
    end
    req = '0;
    wait_idle("rnd_to", 2000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
